// File: rtl/mxv_frame_parser.sv
// Byte-serial command-frame parser for the MxV engine: FE LEN CMD payload EF.
// Streams DATA payload as row/col element writes and commits control commands on a good STOP.
module mxv_frame_parser #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned MAX_N       = 8,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid_i,
  input  logic [WORD_LENGTH-1:0] rx_data_i,
  output logic                   wr_valid_o,
  output logic                   wr_vector_o,
  output logic [IDX_W-1:0]       wr_row_o,
  output logic [IDX_W-1:0]       wr_col_o,
  output logic [WORD_LENGTH-1:0] wr_data_o,
  output logic                   data_done_o,
  output logic                   data_abort_o,
  output logic                   size_valid_o,
  output logic [WORD_LENGTH-1:0] size_n_o,
  output logic                   resend_o,
  output logic                   capture_start_o,
  output logic                   frame_err_o,
  output logic [2:0]             err_code_o
);

  localparam int unsigned W    = WORD_LENGTH;
  localparam int unsigned DW   = 2 * WORD_LENGTH;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [W-1:0] SofByte    = W'(8'hFE);
  localparam logic [W-1:0] EofByte    = W'(8'hEF);
  localparam logic [W-1:0] CmdSetSize = W'(1);
  localparam logic [W-1:0] CmdResend  = W'(2);
  localparam logic [W-1:0] CmdCapture = W'(3);
  localparam logic [W-1:0] CmdData    = W'(4);

  typedef enum logic [2:0] {StIdle, StLen, StCmd, StPayload, StStop, StError} state_e;

  state_e           state_q;
  logic [W-1:0]     len_q, cmd_q, cnt_q, pend_q, size_q;
  logic [IDX_W-1:0] row_q, col_q;
  logic             vec_q, wrote_q;
  logic [TmoW-1:0]  tmo_q;

  logic             wr_valid_q, wr_vector_q;
  logic [IDX_W-1:0] wr_row_q, wr_col_q;
  logic [W-1:0]     wr_data_q;
  logic             data_done_q, data_abort_q, size_valid_q, resend_q, capture_q, frame_err_q;
  logic [2:0]       err_code_q;

  logic          active, tmo_hit;
  logic [DW-1:0] data_len;
  logic [2:0]    fail_code;

  assign active  = (state_q == StLen) || (state_q == StCmd) ||
                   (state_q == StPayload) || (state_q == StStop);
  assign tmo_hit = (TIMEOUT_CYC != 0) && active && !rx_valid_i &&
                   (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  // Required DATA LEN depends on which half (matrix or vector) the toggle expects next.
  always_comb begin
    data_len = vec_q ? DW'(size_q) + DW'(1) : DW'(size_q) * DW'(size_q) + DW'(1);
  end

  always_comb begin
    fail_code = 3'd0;
    if (tmo_hit) begin
      fail_code = 3'd4;
    end else if (rx_valid_i) begin
      case (state_q)
        StCmd: begin
          if (rx_data_i == CmdData && size_q == '0) begin
            fail_code = 3'd6;
          end else begin
            case (rx_data_i)
              CmdSetSize:            if (len_q != W'(2)) fail_code = 3'd2;
              CmdResend, CmdCapture: if (len_q != W'(1)) fail_code = 3'd2;
              CmdData:               if (DW'(len_q) != data_len) fail_code = 3'd2;
              default:               fail_code = 3'd1;
            endcase
          end
        end
        StPayload: begin
          if (cmd_q == CmdSetSize && (rx_data_i == '0 || rx_data_i > W'(MAX_N))) begin
            fail_code = 3'd5;
          end
        end
        StStop:  if (rx_data_i != EofByte) fail_code = 3'd3;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cmd_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      size_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      vec_q        <= 1'b0;
      wrote_q      <= 1'b0;
      tmo_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_vector_q  <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
      data_done_q  <= 1'b0;
      data_abort_q <= 1'b0;
      size_valid_q <= 1'b0;
      resend_q     <= 1'b0;
      capture_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      wr_valid_q   <= 1'b0;
      data_done_q  <= 1'b0;
      data_abort_q <= 1'b0;
      size_valid_q <= 1'b0;
      resend_q     <= 1'b0;
      capture_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      tmo_q        <= (rx_valid_i || !active) ? '0 : tmo_q + TmoW'(1);
      if (fail_code != 3'd0) begin
        state_q      <= StError;
        frame_err_q  <= 1'b1;
        err_code_q   <= fail_code;
        data_abort_q <= wrote_q;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rx_valid_i && rx_data_i == SofByte) begin
              state_q <= StLen;
              wrote_q <= 1'b0;
            end
          end
          StLen: begin
            if (rx_valid_i) begin
              len_q   <= rx_data_i;
              state_q <= StCmd;
            end
          end
          StCmd: begin
            if (rx_valid_i) begin
              cmd_q   <= rx_data_i;
              row_q   <= '0;
              col_q   <= '0;
              cnt_q   <= len_q - W'(1);
              state_q <= (len_q == W'(1)) ? StStop : StPayload;
            end
          end
          StPayload: begin
            if (rx_valid_i) begin
              cnt_q <= cnt_q - W'(1);
              if (cnt_q == W'(1)) state_q <= StStop;
              if (cmd_q == CmdSetSize) pend_q <= rx_data_i;
              if (cmd_q == CmdData) begin
                wr_valid_q  <= 1'b1;
                wr_vector_q <= vec_q;
                wr_row_q    <= vec_q ? '0 : row_q;
                wr_col_q    <= col_q;
                wr_data_q   <= rx_data_i;
                wrote_q     <= 1'b1;
                if (!vec_q && col_q == IDX_W'(size_q - W'(1))) begin
                  col_q <= '0;
                  row_q <= row_q + IDX_W'(1);
                end else begin
                  col_q <= col_q + IDX_W'(1);
                end
              end
            end
          end
          StStop: begin
            if (rx_valid_i) begin
              state_q <= StIdle;
              case (cmd_q)
                CmdSetSize: begin
                  size_q       <= pend_q;
                  vec_q        <= 1'b0;
                  size_valid_q <= 1'b1;
                end
                CmdResend:  resend_q <= 1'b1;
                CmdCapture: begin
                  capture_q <= 1'b1;
                  vec_q     <= 1'b0;
                end
                CmdData: begin
                  data_done_q <= 1'b1;
                  vec_q       <= ~vec_q;
                end
                default: ;
              endcase
            end
          end
          StError: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wr_valid_o      = wr_valid_q;
  assign wr_vector_o     = wr_vector_q;
  assign wr_row_o        = wr_row_q;
  assign wr_col_o        = wr_col_q;
  assign wr_data_o       = wr_data_q;
  assign data_done_o     = data_done_q;
  assign data_abort_o    = data_abort_q;
  assign size_valid_o    = size_valid_q;
  assign size_n_o        = size_q;
  assign resend_o        = resend_q;
  assign capture_start_o = capture_q;
  assign frame_err_o     = frame_err_q;
  assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_mxv_frame_parser.sv
// Bench for mxv_frame_parser: directed frames plus random frames scored against a frame-level model.
module tb_mxv_frame_parser;
  localparam int unsigned WL   = 8;
  localparam int unsigned MAXN = 8;
  localparam int unsigned IW   = 4;
  localparam int unsigned TMO  = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [WL-1:0] rx_data = '0;
  logic          wr_valid_o, wr_vector_o, data_done_o, data_abort_o, size_valid_o;
  logic          resend_o, capture_start_o, frame_err_o;
  logic [IW-1:0] wr_row_o, wr_col_o;
  logic [WL-1:0] wr_data_o, size_n_o;
  logic [2:0]    err_code_o;

  always #5 clk = ~clk;

  mxv_frame_parser #(
    .WORD_LENGTH(WL), .MAX_N(MAXN), .IDX_W(IW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .wr_valid_o(wr_valid_o), .wr_vector_o(wr_vector_o), .wr_row_o(wr_row_o),
    .wr_col_o(wr_col_o), .wr_data_o(wr_data_o), .data_done_o(data_done_o),
    .data_abort_o(data_abort_o), .size_valid_o(size_valid_o), .size_n_o(size_n_o),
    .resend_o(resend_o), .capture_start_o(capture_start_o), .frame_err_o(frame_err_o),
    .err_code_o(err_code_o)
  );

  int n_checks = 0;
  int n_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: log every write and count every pulse cycle.
  logic [31:0] wlog [4096];
  int wn = 0, c_done = 0, c_abort = 0, c_size = 0, c_res = 0, c_cap = 0, c_err = 0;
  always @(negedge clk) begin
    if (wr_valid_o && wn < 4096) begin
      wlog[wn] <= {12'd0, wr_vector_o, 3'd0, wr_row_o, wr_col_o, wr_data_o};
      wn       <= wn + 1;
    end
    c_done  <= c_done + int'(data_done_o);
    c_abort <= c_abort + int'(data_abort_o);
    c_size  <= c_size + int'(size_valid_o);
    c_res   <= c_res + int'(resend_o);
    c_cap   <= c_cap + int'(capture_start_o);
    c_err   <= c_err + int'(frame_err_o);
  end

  // Model state and per-frame expectations.
  int m_size = 0, m_vec = 0, m_last_err = 0;
  logic [7:0]  frm[$];
  logic [31:0] e_w[$];
  bit          wr_at[$];
  int          e_done, e_abort, e_size, e_res, e_cap, e_err;
  bit          e_tmo;
  logic [4:0]  e_last;  // {size_valid, resend, capture, done, err} after the final byte

  function automatic int req_len(input int cmd);
    case (cmd)
      1:       return 2;
      2, 3:    return 1;
      4:       return (m_vec != 0) ? m_size + 1 : m_size * m_size + 1;
      default: return -1;
    endcase
  endfunction

  function automatic void mfail(input int code, input int ab);
    e_err = 1;
    e_abort = ab;
    m_last_err = code;
    if (code != 4) e_last = 5'b00001;
    else e_tmo = 1'b1;
  endfunction

  function automatic void model_frame();
    int len, cmd, npay, got, nw, pend, b;
    bit bad5;
    e_w = {};
    wr_at = {};
    foreach (frm[i]) wr_at.push_back(1'b0);
    {e_done, e_abort, e_size, e_res, e_cap, e_err} = '0;
    e_tmo = 1'b0;
    e_last = 5'b0;
    len = int'(frm[1]);
    cmd = int'(frm[2]);
    nw = 0;
    pend = 0;
    bad5 = 1'b0;
    if (cmd == 4 && m_size == 0) mfail(6, 0);
    else if (cmd < 1 || cmd > 4) mfail(1, 0);
    else if (len != req_len(cmd)) mfail(2, 0);
    else begin
      npay = len - 1;
      got = frm.size() - 3;
      for (int k = 0; k < npay && k < got; k++) begin
        b = int'(frm[3+k]);
        if (cmd == 4) begin
          if (m_vec != 0) e_w.push_back({12'd0, 1'b1, 3'd0, 4'd0, 4'(k), 8'(b)});
          else e_w.push_back({12'd0, 1'b0, 3'd0, 4'(k / m_size), 4'(k % m_size), 8'(b)});
          wr_at[3+k] = 1'b1;
          nw++;
        end
        if (cmd == 1) begin
          if (b == 0 || b > int'(MAXN)) begin
            mfail(5, 0);
            bad5 = 1'b1;
            break;
          end
          pend = b;
        end
      end
      if (!bad5) begin
        if (got < npay + 1) mfail(4, (nw > 0) ? 1 : 0);
        else if (frm[3+npay] != 8'hEF) mfail(3, (nw > 0) ? 1 : 0);
        else begin
          case (cmd)
            1: begin m_size = pend; m_vec = 0; e_size = 1; e_last = 5'b10000; end
            2: begin e_res = 1; e_last = 5'b01000; end
            3: begin e_cap = 1; m_vec = 0; e_last = 5'b00100; end
            default: begin e_done = 1; m_vec = 1 - m_vec; e_last = 5'b00010; end
          endcase
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame();
    int s_wn, s_done, s_abort, s_size, s_res, s_cap, s_err;
    s_wn = wn; s_done = c_done; s_abort = c_abort; s_size = c_size;
    s_res = c_res; s_cap = c_cap; s_err = c_err;
    model_frame();
    foreach (frm[i]) begin
      send_byte(frm[i], int'($urandom_range(0, 3)));
      if (i >= 3) check_eq("wr_latency", 32'(wr_valid_o), 32'(wr_at[i]));
      if (i == frm.size() - 1 && !e_tmo)
        check_eq("event_latency",
                 32'({size_valid_o, resend_o, capture_start_o, data_done_o, frame_err_o}),
                 32'(e_last));
    end
    repeat (TMO + 6) @(negedge clk);
    check_eq("n_writes", 32'(wn - s_wn), 32'(e_w.size()));
    for (int k = 0; k < e_w.size() && s_wn + k < wn; k++)
      check_eq("write", wlog[s_wn+k], e_w[k]);
    check_eq("n_done", 32'(c_done - s_done), 32'(e_done));
    check_eq("n_abort", 32'(c_abort - s_abort), 32'(e_abort));
    check_eq("n_size_valid", 32'(c_size - s_size), 32'(e_size));
    check_eq("n_resend", 32'(c_res - s_res), 32'(e_res));
    check_eq("n_capture", 32'(c_cap - s_cap), 32'(e_cap));
    check_eq("n_frame_err", 32'(c_err - s_err), 32'(e_err));
    check_eq("err_code", 32'(err_code_o), 32'(m_last_err));
    check_eq("size_n", 32'(size_n_o), 32'(m_size));
  endtask

  task automatic gen_frame(input int kind);
    int l;
    logic [7:0] v;
    frm = {8'hFE};
    case (kind)
      0: frm = {frm, 8'h02, 8'h01, 8'($urandom_range(1, MAXN)), 8'hEF};
      1: begin
        v = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXN + 1, 255));
        frm = {frm, 8'h02, 8'h01, v};
      end
      2: frm = {frm, 8'h01, 8'h02, 8'hEF};
      3: frm = {frm, 8'h01, 8'h03, 8'hEF};
      4, 5: begin
        if (m_size == 0) frm = {frm, 8'h05, 8'h04};
        else begin
          l = req_len(4);
          frm = {frm, 8'(l), 8'h04};
          for (int k = 0; k < l - 1; k++) frm.push_back(8'($urandom));
          frm.push_back(8'hEF);
        end
      end
      6: begin
        if (m_size == 0) frm = {frm, 8'h03, 8'h04};
        else begin
          l = req_len(4) + (($urandom_range(0, 1) != 0) ? 1 : -1);
          frm = {frm, 8'(l), 8'h04};
        end
      end
      7: frm = {frm, 8'h01,
                ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(5, 255))};
      8: begin
        v = 8'hEF;
        while (v == 8'hEF) v = 8'($urandom);
        frm = {frm, 8'h01, 8'h02, v};
      end
      default: begin
        if (m_size == 0) frm = {frm, 8'h02, 8'h01};
        else begin
          l = req_len(4);
          frm = {frm, 8'(l), 8'h04};
          for (int k = 0; k < int'($urandom_range(0, l - 1)); k++) frm.push_back(8'($urandom));
        end
      end
    endcase
  endtask

  initial begin
    #1;
    check_eq("rst_wr", 32'({wr_valid_o, wr_vector_o, wr_row_o, wr_col_o, wr_data_o}), 32'd0);
    check_eq("rst_ctl", 32'({data_done_o, data_abort_o, size_valid_o, resend_o, capture_start_o,
                             frame_err_o, err_code_o, size_n_o}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    frm = {8'hFE, 8'h03, 8'h04};                               run_frame();  // N not set
    frm = {8'hFE, 8'h02, 8'h01, 8'h09};                        run_frame();  // N too large
    frm = {8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};                 run_frame();
    frm = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};                 run_frame();
    frm = {8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF}; run_frame();
    frm = {8'hFE, 8'h03, 8'h04, 8'h01, 8'h02, 8'hEF};          run_frame();
    frm = {8'hFE, 8'h04, 8'h04};                               run_frame();  // bad LEN
    frm = {8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B};                 run_frame();  // timeout
    frm = {8'hFE, 8'h05, 8'h04, 8'hFE, 8'hEF, 8'h01, 8'h02, 8'hEF}; run_frame();
    frm = {8'hFE, 8'h01, 8'h02, 8'h55};                        run_frame();  // bad STOP
    frm = {8'hFE, 8'h01, 8'h02, 8'hEF};                        run_frame();
    frm = {8'hFE, 8'h01, 8'h03, 8'hEF};                        run_frame();

    for (int f = 0; f < 150; f++) begin
      gen_frame(int'($urandom_range(0, 9)));
      run_frame();
    end

    // Reset mid-payload abandons the frame and clears size_n.
    frm = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}; run_frame();
    send_byte(8'hFE, 0);
    send_byte(8'h05, 0);
    send_byte(8'h04, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h0B, 0);
    reset = 1'b0;
    #1;
    check_eq("midrst_wr", 32'({wr_valid_o, wr_vector_o, wr_row_o, wr_col_o, wr_data_o}), 32'd0);
    check_eq("midrst_ctl", 32'({data_done_o, data_abort_o, size_valid_o, resend_o,
                                capture_start_o, frame_err_o, err_code_o, size_n_o}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_size = 0;
    m_vec = 0;
    m_last_err = 0;
    frm = {8'hFE, 8'h03, 8'h04}; run_frame();
    frm = {8'hFE, 8'h02, 8'h01, 8'h01, 8'hEF}; run_frame();
    frm = {8'hFE, 8'h02, 8'h04, 8'h77, 8'hEF}; run_frame();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
